// File: rtl/lsr_pulse_ctrl.sv
// Drives active-low set/reset pulses into an SR latch with a dead time after each pulse.
// A synchronised copy of the latch output confirms the pulse took effect (DONE) or times out (ERR).
module lsr_pulse_ctrl #(
    parameter int PW          = 2,
    parameter int DT          = 1,
    parameter int TO          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic CP,
    input  logic CD,
    input  logic REQ_VALID,
    output logic REQ_READY,
    input  logic REQ_VAL,
    output logic S_N,
    output logic R_N,
    input  logic Q_FB,
    output logic STATE_Q,
    output logic DONE,
    output logic ERR
);

    localparam int MAX_PD  = (PW > DT) ? PW : DT;
    localparam int MAX_CNT = (MAX_PD > TO) ? MAX_PD : TO;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] PW_LOAD = CW'(PW - 1);
    localparam logic [CW-1:0] DT_LOAD = CW'(DT - 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(TO - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        DEAD,
        CHECK
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          next_cnt;
    logic                   target;
    logic                   next_target;
    logic                   next_s_n;
    logic                   next_r_n;
    logic                   next_done;
    logic                   next_err;
    logic [SYNC_STAGES-1:0] sync_q;

    // Q_FB is asynchronous to CP, so it passes through a plain shift-register synchroniser.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Q_FB};
        end
    end

    assign STATE_Q   = sync_q[SYNC_STAGES-1];
    assign REQ_READY = (state == IDLE);

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= 1'b0;
            S_N    <= 1'b1;
            R_N    <= 1'b1;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            target <= next_target;
            S_N    <= next_s_n;
            R_N    <= next_r_n;
            DONE   <= next_done;
            ERR    <= next_err;
        end
    end

    // Pulse outputs come from the next state so they are registered and cannot glitch or overlap.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_target = target;
        next_s_n    = 1'b1;
        next_r_n    = 1'b1;
        next_done   = 1'b0;
        next_err    = 1'b0;

        unique case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    next_state  = PULSE;
                    next_cnt    = PW_LOAD;
                    next_target = REQ_VAL;
                    next_s_n    = ~REQ_VAL;
                    next_r_n    = REQ_VAL;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    next_state = DEAD;
                    next_cnt   = DT_LOAD;
                end else begin
                    next_cnt = cnt - CNT_ONE;
                    next_s_n = ~target;
                    next_r_n = target;
                end
            end
            DEAD: begin
                if (cnt == '0) begin
                    next_state = CHECK;
                    next_cnt   = TO_LOAD;
                end else begin
                    next_cnt = cnt - CNT_ONE;
                end
            end
            CHECK: begin
                if (STATE_Q == target) begin
                    next_state = IDLE;
                    next_done  = 1'b1;
                end else if (cnt == '0) begin
                    next_state = IDLE;
                    next_err   = 1'b1;
                end else begin
                    next_cnt = cnt - CNT_ONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsr_pulse_ctrl.sv
// Bench for lsr_pulse_ctrl: an ideal SR latch closes Q_FB, with an optional stuck-at override,
// and each request's timeline is predicted from the pulse, dead-time and timeout rules.
module tb_lsr_pulse_ctrl;

    localparam int PW          = 2;
    localparam int DT          = 1;
    localparam int TO          = 8;
    localparam int SYNC_STAGES = 2;

    logic CP;
    logic CD;
    logic REQ_VALID;
    logic REQ_READY;
    logic REQ_VAL;
    logic S_N;
    logic R_N;
    logic Q_FB;
    logic STATE_Q;
    logic DONE;
    logic ERR;

    logic latch_q;
    bit   stuck_en;
    logic stuck_val;
    logic cur_q;
    int   checks;
    int   fails;
    int   xfers;
    int   viol;

    lsr_pulse_ctrl #(
        .PW(PW),
        .DT(DT),
        .TO(TO),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CP(CP),
        .CD(CD),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_VAL(REQ_VAL),
        .S_N(S_N),
        .R_N(R_N),
        .Q_FB(Q_FB),
        .STATE_Q(STATE_Q),
        .DONE(DONE),
        .ERR(ERR)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Ideal active-low SR latch
    initial latch_q = 1'b0;
    always @(S_N or R_N) begin
        if (S_N === 1'b0) latch_q = 1'b1;
        else if (R_N === 1'b0) latch_q = 1'b0;
    end
    assign Q_FB = stuck_en ? stuck_val : latch_q;

    always @(posedge CP) begin
        if (CD && REQ_VALID && REQ_READY) xfers++;
    end

    always @(negedge CP) begin
        if (CD) begin
            if (S_N === 1'b0 && R_N === 1'b0) viol++;
            if (DONE === 1'b1 && ERR === 1'b1) viol++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Caller must be just after a negedge with the block idle.
    task automatic do_request(input logic val, input logic next_val, input bit hold_valid,
                              input string name);
        logic       fb_before;
        logic       fb_after;
        int         c0;
        int         match;
        int         first_ok;
        int         end_c;
        bit         is_done;
        logic [4:0] obs;
        logic [4:0] exp_v;
        REQ_VALID = 1'b1;
        REQ_VAL   = val;
        checks++;
        if (REQ_READY !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s ready_before: got %b expected 1", name, REQ_READY);
        end
        fb_before = stuck_en ? stuck_val : cur_q;
        fb_after  = stuck_en ? stuck_val : val;
        c0 = PW + DT + 1;
        if (fb_before == val) match = 0;
        else if (fb_after == val) match = 1 + SYNC_STAGES;
        else match = 1000;
        first_ok = (match > c0) ? match : c0;
        if (first_ok <= c0 + TO - 1) begin
            is_done = 1'b1;
            end_c   = first_ok + 1;
        end else begin
            is_done = 1'b0;
            end_c   = c0 + TO;
        end
        for (int c = 1; c <= end_c; c++) begin
            @(negedge CP);
            obs = {S_N, R_N, DONE, ERR, REQ_READY};
            exp_v[4] = !(val == 1'b1 && c >= 1 && c <= PW);
            exp_v[3] = !(val == 1'b0 && c >= 1 && c <= PW);
            exp_v[2] = is_done && (c == end_c);
            exp_v[1] = !is_done && (c == end_c);
            exp_v[0] = (c == end_c);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL %s cycle k+%0d {S_N,R_N,DONE,ERR,READY}: got %b expected %b",
                         name, c, obs, exp_v);
            end
            if (c == 1) begin
                if (hold_valid) REQ_VAL = next_val;
                else REQ_VALID = 1'b0;
            end
        end
        checks++;
        if (STATE_Q !== fb_after) begin
            fails++;
            $display("[TB] FAIL %s state_q: got %b expected %b", name, STATE_Q, fb_after);
        end
        cur_q = val;
    endtask

    task automatic settle();
        repeat (SYNC_STAGES + 2) @(negedge CP);
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        CD = 1'b0;
        repeat (2) @(negedge CP);
        obs = {S_N, R_N, DONE, ERR, STATE_Q};
        checks++;
        if (obs !== 5'b11000) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b expected 11000", obs);
        end
        CD = 1'b1;
        @(negedge CP);
        checks++;
        if (REQ_READY !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", REQ_READY);
        end
    endtask

    task automatic test_set_clear();
        @(negedge CP);
        do_request(1'b1, 1'b0, 1'b0, "set");
        @(negedge CP);
        do_request(1'b0, 1'b0, 1'b0, "clear");
    endtask

    task automatic test_stuck();
        @(negedge CP);
        stuck_en  = 1'b1;
        stuck_val = 1'b0;
        settle();
        do_request(1'b1, 1'b0, 1'b0, "stuck_set");
        stuck_en = 1'b0;
        settle();
    endtask

    task automatic test_back_to_back();
        int start_x;
        int vb;
        @(negedge CP);
        start_x = xfers;
        vb      = viol;
        do_request(1'b1, 1'b0, 1'b1, "b2b_1");
        do_request(1'b0, 1'b1, 1'b1, "b2b_2");
        do_request(1'b1, 1'b1, 1'b0, "b2b_3");
        repeat (3) @(negedge CP);
        checks++;
        if (xfers - start_x !== 3) begin
            fails++;
            $display("[TB] FAIL b2b_transfers: got %0d expected 3", xfers - start_x);
        end
        checks++;
        if (viol !== vb) begin
            fails++;
            $display("[TB] FAIL b2b_overlap: got %0d violations expected 0", viol - vb);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] obs;
        bit         seen;
        @(negedge CP);
        do_request(1'b0, 1'b0, 1'b0, "pre_clear");
        REQ_VALID = 1'b1;
        REQ_VAL   = 1'b1;
        @(negedge CP);
        REQ_VALID = 1'b0;
        @(negedge CP);
        checks++;
        if (S_N !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_pulse_s_n: got %b expected 0", S_N);
        end
        #2 CD = 1'b0;
        #1;
        obs = {S_N, R_N, DONE, ERR};
        checks++;
        if (obs !== 4'b1100) begin
            fails++;
            $display("[TB] FAIL async_reset_outputs: got %b expected 1100", obs);
        end
        checks++;
        if (STATE_Q !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset_state_q: got %b expected 0", STATE_Q);
        end
        cur_q = 1'b1;
        @(negedge CP);
        CD   = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CP);
            if (DONE !== 1'b0 || ERR !== 1'b0) seen = 1'b1;
            if (c == SYNC_STAGES) begin
                checks++;
                if (STATE_Q !== cur_q) begin
                    fails++;
                    $display("[TB] FAIL post_reset_state_q: got %b expected %b", STATE_Q, cur_q);
                end
            end
        end
        checks++;
        if (seen) begin
            fails++;
            $display("[TB] FAIL post_reset_no_done_err: got pulse expected none");
        end
        do_request(1'b1, 1'b0, 1'b0, "post_reset_set");
    endtask

    task automatic test_random();
        logic v;
        for (int i = 0; i < 12; i++) begin
            @(negedge CP);
            repeat ($urandom_range(0, 3)) @(negedge CP);
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                stuck_en  = 1'b1;
                stuck_val = 1'($urandom_range(0, 1));
                settle();
            end
            do_request(v, 1'b0, 1'b0, "random");
            if (stuck_en) begin
                stuck_en = 1'b0;
                settle();
            end
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        xfers     = 0;
        viol      = 0;
        cur_q     = 1'b0;
        stuck_en  = 1'b0;
        stuck_val = 1'b0;
        REQ_VALID = 1'b0;
        REQ_VAL   = 1'b0;
        CD        = 1'b0;
        test_reset();
        test_set_clear();
        test_stuck();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        checks++;
        if (viol !== 0) begin
            fails++;
            $display("[TB] FAIL invariants: got %0d violations expected 0", viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
